// File: rtl/bs_exec.sv
// Bit-serial execute sequencer that drives a two-entry register file LSB first (LOAD/ADD/SUB/ASR).
// Latency: 9 cycles start-to-done for LOAD/ADD/SUB, amt+1 for ASR. i_start is accepted only in IDLE and is never queued.
module bs_exec #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [1:0]   i_op,
  input  logic         i_rd,
  input  logic         i_rs,
  input  logic [W-1:0] i_imm,
  input  logic [2:0]   i_amt,
  input  logic         i_gpr_bit,
  input  logic [W-1:0] i_ry,
  input  logic [W-1:0] i_rx,
  output logic         o_con_shift,
  output logic         o_con_sign,
  output logic         o_data_in,
  output logic         o_data_sign,
  output logic         o_rd_addr,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_carry,
  output logic         o_zero
);

  localparam int IW = $clog2(W);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(W);

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_ASR  = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [1:0]    op_q;
  logic          rd_q;
  logic [W-1:0]  snap_q;
  logic          sign_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic          zacc_q;

  logic          bit_a, bit_b, sum, cout, last;

  // Serial full adder; SUB inverts the snapshot bit and starts with carry-in 1.
  assign bit_a = i_gpr_bit;
  assign bit_b = snap_q[idx_q] ^ (op_q == OP_SUB);
  assign sum   = bit_a ^ bit_b ^ carry_q;
  assign cout  = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
  assign last  = (cnt_q == CW'(1));

  assign o_rd_addr = rd_q;

  always_comb begin
    state_nx    = state;
    o_con_shift = 1'b0;
    o_con_sign  = 1'b0;
    o_data_in   = 1'b0;
    o_data_sign = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nx = (i_op == OP_ASR && i_amt == 3'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        o_busy      = 1'b1;
        o_con_shift = 1'b1;
        if (op_q == OP_ASR) begin
          o_con_sign  = 1'b1;
          o_data_sign = sign_q;
        end else if (op_q == OP_LOAD) begin
          o_data_in = snap_q[idx_q];
        end else begin
          o_data_in = sum;
        end
        if (last) state_nx = DONE;
      end
      DONE: begin
        o_busy   = 1'b1;
        o_done   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      op_q    <= OP_LOAD;
      rd_q    <= 1'b0;
      snap_q  <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      o_carry <= 1'b0;
      o_zero  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (i_start) begin
            op_q    <= i_op;
            rd_q    <= i_rd;
            snap_q  <= (i_op == OP_LOAD) ? i_imm : (i_rs ? i_rx : i_ry);
            sign_q  <= i_rd ? i_rx[W-1] : i_ry[W-1];
            cnt_q   <= (i_op == OP_ASR) ? CW'(i_amt) : CNT_FULL;
            idx_q   <= '0;
            carry_q <= (i_op == OP_SUB);
            zacc_q  <= 1'b1;
          end
        end
        RUN: begin
          idx_q <= idx_q + IW'(1);
          cnt_q <= cnt_q - CW'(1);
          if (op_q != OP_ASR) begin
            carry_q <= cout;
            zacc_q  <= zacc_q & ~o_data_in;
            // Flags land on the final shift edge so they are valid alongside o_done.
            if (last) begin
              o_carry <= (op_q == OP_LOAD) ? 1'b0 : cout;
              o_zero  <= zacc_q & ~o_data_in;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
